// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-port data memory
// with combinational read data.
//
// Every transaction runs IDLE -> ACCESS -> RESP, so a request sampled in IDLE
// is acknowledged three cycles later counting the sample cycle. Addresses with
// any bit set at or above ADDR_BITS are rejected: no memory access takes place,
// and the requester gets ack+err with rdata forced to 0.
//
// Ports:
//   clk, rst_n               clock (shared with the memory), async active-low reset
//   a_req/a_we/a_addr/a_wdata  port A command (CPU data); held until ack
//   b_req/b_we/b_addr/b_wdata  port B command (debug/loader); held until ack
//   a_ack/a_err/a_rdata      port A one-cycle completion/error pulse, registered read data
//   b_ack/b_err/b_rdata      port B one-cycle completion/error pulse, registered read data
//   mem_ena/mem_wena         memory enable / write enable (high only in ACCESS)
//   mem_addr/mem_wdata       memory address / write data (hold their last value)
//   mem_rdata                combinational memory read data
//   busy                     high whenever the FSM is not in IDLE
//   txn_cnt                  saturating count of completed transactions
module mem_arbiter #(
    parameter int ADDR_BITS = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_req,
    input  logic             a_we,
    input  logic [31:0]      a_addr,
    input  logic [31:0]      a_wdata,
    input  logic             b_req,
    input  logic             b_we,
    input  logic [31:0]      b_addr,
    input  logic [31:0]      b_wdata,
    output logic             a_ack,
    output logic             a_err,
    output logic [31:0]      a_rdata,
    output logic             b_ack,
    output logic             b_err,
    output logic [31:0]      b_rdata,
    output logic             mem_ena,
    output logic             mem_wena,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic             busy,
    output logic [CNT_W-1:0] txn_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic               last_b_q,    last_b_d;    // 1 = port B was granted last
    logic               cmd_b_q,     cmd_b_d;     // 1 = current command belongs to port B
    logic               cmd_we_q,    cmd_we_d;
    logic [31:0]        cmd_addr_q,  cmd_addr_d;
    logic [31:0]        cmd_wdata_q, cmd_wdata_d;
    logic               mem_ena_q,   mem_ena_d;
    logic               mem_wena_q,  mem_wena_d;
    logic               a_ack_q,     a_ack_d;
    logic               a_err_q,     a_err_d;
    logic [31:0]        a_rdata_q,   a_rdata_d;
    logic               b_ack_q,     b_ack_d;
    logic               b_err_q,     b_err_d;
    logic [31:0]        b_rdata_q,   b_rdata_d;
    logic               busy_q,      busy_d;
    logic [CNT_W-1:0]   txn_cnt_q,   txn_cnt_d;

    logic               grant_b;
    logic               win_we;
    logic [31:0]        win_addr;
    logic [31:0]        win_wdata;
    logic               win_oor;
    logic               cmd_oor;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        last_b_d    = last_b_q;
        cmd_b_d     = cmd_b_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        mem_ena_d   = 1'b0;
        mem_wena_d  = 1'b0;
        a_ack_d     = 1'b0;
        a_err_d     = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_ack_d     = 1'b0;
        b_err_d     = 1'b0;
        b_rdata_d   = b_rdata_q;
        busy_d      = busy_q;
        txn_cnt_d   = txn_cnt_q;

        // B wins alone, or on a tie when A was granted last.
        grant_b   = b_req && (!a_req || !last_b_q);
        win_we    = grant_b ? b_we    : a_we;
        win_addr  = grant_b ? b_addr  : a_addr;
        win_wdata = grant_b ? b_wdata : a_wdata;
        win_oor   = win_addr[31:ADDR_BITS] != '0;
        cmd_oor   = cmd_addr_q[31:ADDR_BITS] != '0;

        unique case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    state_d     = ACCESS;
                    last_b_d    = grant_b;
                    cmd_b_d     = grant_b;
                    cmd_we_d    = win_we;
                    cmd_addr_d  = win_addr;
                    cmd_wdata_d = win_wdata;
                    // Enables are registered so they are high exactly during ACCESS.
                    mem_ena_d   = !win_oor;
                    mem_wena_d  = !win_oor && win_we;
                    busy_d      = 1'b1;
                end
            end
            ACCESS: begin
                state_d = RESP;
                a_ack_d = !cmd_b_q;
                b_ack_d = cmd_b_q;
                a_err_d = !cmd_b_q && cmd_oor;
                b_err_d = cmd_b_q && cmd_oor;
                // Rejected commands report 0; writes leave the port's read data alone.
                if (cmd_oor || !cmd_we_q) begin
                    if (cmd_b_q) b_rdata_d = cmd_oor ? '0 : mem_rdata;
                    else         a_rdata_d = cmd_oor ? '0 : mem_rdata;
                end
                if (!(&txn_cnt_q)) txn_cnt_d = txn_cnt_q + CNT_W'(1);
            end
            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Asynchronous reset clears mem_ena immediately, so an ACCESS cut short by
    // reset never commits its write and never reaches RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_b_q    <= 1'b1;
            cmd_b_q     <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            mem_ena_q   <= 1'b0;
            mem_wena_q  <= 1'b0;
            a_ack_q     <= 1'b0;
            a_err_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_ack_q     <= 1'b0;
            b_err_q     <= 1'b0;
            b_rdata_q   <= '0;
            busy_q      <= 1'b0;
            txn_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            last_b_q    <= last_b_d;
            cmd_b_q     <= cmd_b_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            mem_ena_q   <= mem_ena_d;
            mem_wena_q  <= mem_wena_d;
            a_ack_q     <= a_ack_d;
            a_err_q     <= a_err_d;
            a_rdata_q   <= a_rdata_d;
            b_ack_q     <= b_ack_d;
            b_err_q     <= b_err_d;
            b_rdata_q   <= b_rdata_d;
            busy_q      <= busy_d;
            txn_cnt_q   <= txn_cnt_d;
        end
    end

    assign a_ack     = a_ack_q;
    assign a_err     = a_err_q;
    assign a_rdata   = a_rdata_q;
    assign b_ack     = b_ack_q;
    assign b_err     = b_err_q;
    assign b_rdata   = b_rdata_q;
    assign mem_ena   = mem_ena_q;
    assign mem_wena  = mem_wena_q;
    // The command register only loads in IDLE, so the memory bus holds its last value.
    assign mem_addr  = cmd_addr_q;
    assign mem_wdata = cmd_wdata_q;
    assign busy      = busy_q;
    assign txn_cnt   = txn_cnt_q;

endmodule
